// File: rtl/pool_seq_pkg.sv
// Shared types and constants for the layer-3 pooling channel sequencer.
// Timeout support is compiled in with POOL_SEQ_TIMEOUT_EN.
package pool_seq_pkg;

    localparam int CH_W        = 5;
    localparam int BASE_W      = 12;
    localparam int NUM_CH_DEF  = 16;
    localparam int MAP_OUT_DEF = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_FIN
    } state_t;

    // Counters hold n-1 down to 0, so they need clog2(n) bits (min 1).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_seq_cnt.sv
// Loadable saturating down-counter with zero flag.
// Used for the inter-channel gap and the optional RUN timeout.
module pool_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pool_layer_seq.sv
// Channel sequencer for the layer-3 2x2 max-pooling engine.
// Optional RUN-state timeout: define POOL_SEQ_TIMEOUT_EN.
module pool_layer_seq
    import pool_seq_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int MAP_OUT     = MAP_OUT_DEF,
    parameter int BASE_OFFSET = 0,
    parameter int GAP_CYC     = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pool_done,
    output logic              cal_en,
    output logic [BASE_W-1:0] base_position,
    output logic              ch_start,
    output logic [CH_W-1:0]   ch_idx,
    output logic              ch_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = cnt_w(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP_CYC - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [BASE_W-1:0] BASE0 = BASE_W'(BASE_OFFSET);
    localparam logic [BASE_W-1:0] STRIDE = BASE_W'(MAP_OUT);

    if (BASE_OFFSET + NUM_CH * MAP_OUT >= 2 ** BASE_W) begin : g_bad_base
        $error("pool_layer_seq: base_position range overflows");
    end
    if (NUM_CH < 1 || NUM_CH > 2 ** CH_W) begin : g_bad_ch
        $error("pool_layer_seq: NUM_CH out of range");
    end
    if (GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
        $error("pool_layer_seq: GAP_CYC/TIMEOUT_CYC must be >= 1");
    end

    state_t state;
    logic   gap_zero;
    logic   tmo_hit;

    // Gap counter is reloaded every cycle outside GAP, so it is
    // primed with GAP_CYC-1 on the RUN->GAP transition.
    pool_seq_cnt #(
        .W (GAP_W)
    ) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != S_GAP),
        .load_val (GAP_LD),
        .dec      (state == S_GAP),
        .zero     (gap_zero)
    );

`ifdef POOL_SEQ_TIMEOUT_EN
    localparam int TMO_W = cnt_w(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TIMEOUT_CYC - 1);

    logic tmo_zero;

    pool_seq_cnt #(
        .W (TMO_W)
    ) u_tmo_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != S_RUN),
        .load_val (TMO_LD),
        .dec      (state == S_RUN),
        .zero     (tmo_zero)
    );

    assign tmo_hit = tmo_zero;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cal_en        <= 1'b0;
            base_position <= '0;
            ch_start      <= 1'b0;
            ch_idx        <= '0;
            ch_done       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            ch_start <= 1'b0;
            ch_done  <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                state  <= S_IDLE;
                cal_en <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state         <= S_LOAD;
                            busy          <= 1'b1;
                            ch_idx        <= '0;
                            base_position <= BASE0;
                            err           <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        state    <= S_RUN;
                        cal_en   <= 1'b1;
                        ch_start <= 1'b1;
                    end
                    S_RUN: begin
                        if (pool_done) begin
                            cal_en  <= 1'b0;
                            ch_done <= 1'b1;
                            if (ch_idx == LAST_CH) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                            end else begin
                                state         <= S_GAP;
                                ch_idx        <= ch_idx + 1'b1;
                                base_position <= base_position + STRIDE;
                            end
                        end else if (tmo_hit) begin
                            state  <= S_FIN;
                            cal_en <= 1'b0;
                            err    <= 1'b1;
                            done   <= 1'b1;
                        end
                    end
                    // Engine may still hold pool_done from the last map.
                    S_GAP: begin
                        if (gap_zero && !pool_done) begin
                            state <= S_LOAD;
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_layer_seq.sv
// Scoreboard bench for pool_layer_seq with a behavioural pooling engine.
// Timeout scenario runs only when POOL_SEQ_TIMEOUT_EN is defined.
module tb_pool_layer_seq;

    localparam int NCH  = 16;
    localparam int MOUT = 25;
    localparam int BOFF = 0;
    localparam int GAP  = 3;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pool_done = 1'b0;
    logic        cal_en;
    logic [11:0] base_position;
    logic        ch_start;
    logic [4:0]  ch_idx;
    logic        ch_done;
    logic        busy;
    logic        done;
    logic        err;

    pool_layer_seq #(
        .NUM_CH      (NCH),
        .MAP_OUT     (MOUT),
        .BASE_OFFSET (BOFF),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .pool_done     (pool_done),
        .cal_en        (cal_en),
        .base_position (base_position),
        .ch_start      (ch_start),
        .ch_idx        (ch_idx),
        .ch_done       (ch_done),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int base;
        int gap;
    } ch_exp_t;

    typedef struct {
        bit err;
        int nch;
    } done_exp_t;

    ch_exp_t   ch_q[$];
    done_exp_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_total = 0;
    int mon_total = 0;
    int low_run = 0;

    int eng_hold = 0;
    int eng_silent = -1;
    int eng_cnt = 0;
    int eng_dly = 10;
    int eng_hcnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Engine: pool_done rises after eng_dly enabled cycles and lingers
    // eng_hold cycles after cal_en falls.
    always @(negedge clk) begin
        if (cal_en) begin
            eng_hcnt = 0;
            if (int'(ch_idx) == eng_silent) begin
                pool_done = 1'b0;
            end else begin
                eng_cnt++;
                pool_done = (eng_cnt >= eng_dly);
            end
        end else begin
            eng_cnt = 0;
            if (pool_done && eng_hcnt < eng_hold) begin
                eng_hcnt++;
            end else begin
                pool_done = 1'b0;
                eng_dly = $urandom_range(5, 40);
            end
        end
    end

    // Monitor: pops expectations on ch_start and done.
    always @(negedge clk) begin
        ch_exp_t   ce;
        done_exp_t de;
        if (ch_done) mon_total++;
        if (ch_start) begin
            if (ch_q.size() == 0) begin
                fail("ch_start", "got pulse required none");
            end else begin
                ce = ch_q.pop_front();
                check("ch_idx", 32'(ch_idx), ce.idx);
                check("base_position", 32'(base_position), ce.base);
                check("cal_en_at_start", 32'(cal_en), 1);
                check("cal_en_low_len", low_run, ce.gap);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                fail("done", "got pulse required none");
            end else begin
                de = done_q.pop_front();
                check("err_at_done", 32'(err), 32'(de.err));
                check("ch_done_count", mon_total, de.nch);
                check("cal_en_at_done", 32'(cal_en), 0);
            end
        end
        if (!busy || cal_en) low_run = 0;
        else low_run++;
    end

    // Channel 0 sees only the LOAD cycle low; later channels wait out
    // the gap count and the first cycle pool_done is seen low.
    task automatic push_run(input int nch, input int hold);
        ch_exp_t e;
        for (int i = 0; i < nch; i++) begin
            e.idx  = i;
            e.base = BOFF + i * MOUT;
            if (i == 0) e.gap = 1;
            else e.gap = ((GAP > hold + 1) ? GAP : hold + 1) + 1;
            ch_q.push_back(e);
        end
    endtask

    task automatic push_done(input bit e_err);
        done_exp_t d;
        d.err = e_err;
        d.nch = exp_total;
        done_q.push_back(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail("done_wait", "no done pulse within budget");
    endtask

    task automatic wait_ch(input int k, input int budget);
        int n = 0;
        while (!(ch_start && int'(ch_idx) == k) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(ch_start && int'(ch_idx) == k))
            fail("ch_wait", "channel start not seen within budget");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cal_en"}, 32'(cal_en), 0);
        check({tag, "_base"}, 32'(base_position), 0);
        check({tag, "_ch_start"}, 32'(ch_start), 0);
        check({tag, "_ch_idx"}, 32'(ch_idx), 0);
        check({tag, "_ch_done"}, 32'(ch_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full run, engine drops pool_done immediately.
        eng_hold = 0;
        push_run(NCH, 0);
        exp_total += NCH;
        push_done(1'b0);
        pulse_start();
        check("load_cal_en", 32'(cal_en), 0);
        check("load_busy", 32'(busy), 1);
        check("load_base", 32'(base_position), BOFF);
        wait_done(3000);
        @(negedge clk);
        check("idle_busy_a", 32'(busy), 0);

        // pool_done lingers 5 cycles after cal_en drops.
        eng_hold = 5;
        push_run(NCH, 5);
        exp_total += NCH;
        push_done(1'b0);
        pulse_start();
        wait_done(3000);
        @(negedge clk);
        repeat (8) @(negedge clk);
        eng_hold = 0;

        // start jitter while busy and during FIN.
        push_run(NCH, 0);
        exp_total += NCH;
        push_done(1'b0);
        pulse_start();
        for (int n = 0; n < 3000 && !done; n++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!done) fail("done_wait", "no done pulse within budget");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin_start_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        check("fin_start_no_restart", 32'(busy), 0);

        // Abort during channel 7.
        push_run(8, 0);
        exp_total += 7;
        pulse_start();
        wait_ch(7, 2000);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cal_en", 32'(cal_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ch_done", 32'(ch_done), 0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 0);

        // Restart after abort, random linger.
        hold = $urandom_range(0, 6);
        eng_hold = hold;
        push_run(NCH, hold);
        exp_total += NCH;
        push_done(1'b0);
        pulse_start();
        wait_done(3000);
        @(negedge clk);
        repeat (8) @(negedge clk);
        eng_hold = 0;

`ifdef POOL_SEQ_TIMEOUT_EN
        begin
            int hi;
            eng_silent = 2;
            push_run(3, 0);
            exp_total += 2;
            push_done(1'b1);
            pulse_start();
            wait_ch(2, 2000);
            hi = 0;
            while (cal_en && hi < 200) begin
                hi++;
                @(negedge clk);
            end
            check("timeout_run_len", hi, TMO);
            @(negedge clk);
            check("timeout_err_sticky", 32'(err), 1);
            check("timeout_busy", 32'(busy), 0);
            eng_silent = -1;
            push_run(NCH, 0);
            exp_total += NCH;
            push_done(1'b0);
            pulse_start();
            check("err_cleared", 32'(err), 0);
            wait_done(3000);
            @(negedge clk);
        end
`else
        check("err_tied_low", 32'(err), 0);
`endif

        // Asynchronous reset in the RUN state of channel 3.
        push_run(4, 0);
        exp_total += 3;
        pulse_start();
        wait_ch(3, 2000);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);

        check("ch_q_empty", ch_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("ch_done_total", mon_total, exp_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
